// File: rtl/ho_pkg.sv
// Shared types for the mobile-device handover controller: base-station ids,
// FSM states and default widths.
package ho_pkg;

  localparam int SQ_W_DEF   = 8;
  localparam int DATA_W_DEF = 4;

  typedef enum logic [1:0] {
    BS_NONE = 2'd0,
    BS1     = 2'd1,
    BS2     = 2'd2,
    BS3     = 2'd3
  } bs_id_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SERVING  = 3'd1,
    TRIGGER  = 3'd2,
    HANDOVER = 3'd3
  } md_state_t;

  function automatic logic state_busy(input md_state_t s);
    return (s == TRIGGER) || (s == HANDOVER);
  endfunction

endpackage

// File: rtl/md_best_cell.sv
// Combinational argmax over three signal qualities; ties resolve to the
// lowest-numbered base station.
module md_best_cell
  import ho_pkg::*;
#(
  parameter int SQ_W = SQ_W_DEF
) (
  input  logic [SQ_W-1:0] sq1,
  input  logic [SQ_W-1:0] sq2,
  input  logic [SQ_W-1:0] sq3,
  output bs_id_t          best_id,
  output logic [SQ_W-1:0] best_sq
);

  // Priority chain gives BS1 precedence over BS2 over BS3 on equal values
  always_comb begin
    best_id = BS1;
    best_sq = sq1;
    if ((sq1 >= sq2) && (sq1 >= sq3)) begin
      best_id = BS1;
      best_sq = sq1;
    end else if (sq2 >= sq3) begin
      best_id = BS2;
      best_sq = sq2;
    end else begin
      best_id = BS3;
      best_sq = sq3;
    end
  end

endmodule

// File: rtl/md_handover_ctrl.sv
// Mobile-device side of the handover protocol: registers signal qualities,
// selects the serving BS with hysteresis + time-to-trigger, captures downlink data.
module md_handover_ctrl
  import ho_pkg::*;
#(
  parameter int SQ_W    = SQ_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SQ_MIN  = 32,
  parameter int HYST    = 8,
  parameter int TTT     = 4,
  parameter int HO_TOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SQ_W-1:0]   signalquality1,
  input  logic [SQ_W-1:0]   signalquality2,
  input  logic [SQ_W-1:0]   signalquality3,
  input  logic              compare_enable,
  input  logic [DATA_W-1:0] DM_MD_data,
  output logic [SQ_W-1:0]   MD_DM_sq1,
  output logic [SQ_W-1:0]   MD_DM_sq2,
  output logic [SQ_W-1:0]   MD_DM_sq3,
  output logic [1:0]        MD_DM_target,
  output logic [DATA_W-1:0] final_data,
  output logic              ho_busy,
  output logic              ho_fail
);

  localparam int TTT_W  = (TTT > 1) ? $clog2(TTT + 1) : 1;
  localparam int TOUT_W = (HO_TOUT > 1) ? $clog2(HO_TOUT + 1) : 1;

  localparam logic [SQ_W-1:0]   SQ_MIN_V   = SQ_W'(SQ_MIN);
  localparam logic [SQ_W:0]     HYST_V     = (SQ_W + 1)'(HYST);
  localparam logic [TTT_W-1:0]  TTT_LAST   = TTT_W'(TTT - 1);
  localparam logic [TOUT_W-1:0] TOUT_LAST  = TOUT_W'(HO_TOUT - 1);

  logic [SQ_W-1:0]   sq1_q, sq1_d;
  logic [SQ_W-1:0]   sq2_q, sq2_d;
  logic [SQ_W-1:0]   sq3_q, sq3_d;
  md_state_t         state_q, state_d;
  bs_id_t            target_q, target_d;
  bs_id_t            serving_q, serving_d;
  bs_id_t            prev_q, prev_d;
  bs_id_t            cand_q, cand_d;
  logic [TTT_W-1:0]  ttt_cnt_q, ttt_cnt_d;
  logic [TOUT_W-1:0] tout_cnt_q, tout_cnt_d;
  logic [DATA_W-1:0] final_data_q, final_data_d;
  logic              ho_fail_q, ho_fail_d;

  bs_id_t            best_id_s;
  logic [SQ_W-1:0]   best_sq_s;
  logic [SQ_W-1:0]   serv_sq_s;
  logic              cand_ok_s;
  logic              serv_lost_s;

  md_best_cell #(.SQ_W(SQ_W)) u_best (
    .sq1     (sq1_q),
    .sq2     (sq2_q),
    .sq3     (sq3_q),
    .best_id (best_id_s),
    .best_sq (best_sq_s)
  );

  // Quality of the currently serving BS and the hysteresis comparison (one extra bit, no wrap)
  always_comb begin
    case (serving_q)
      BS1:     serv_sq_s = sq1_q;
      BS2:     serv_sq_s = sq2_q;
      BS3:     serv_sq_s = sq3_q;
      default: serv_sq_s = {SQ_W{1'b0}};
    endcase
    cand_ok_s   = (best_id_s != serving_q) &&
                  ({1'b0, best_sq_s} > ({1'b0, serv_sq_s} + HYST_V));
    serv_lost_s = (serv_sq_s < SQ_MIN_V);
  end

  // Next-state logic for quality registers, handover FSM, counters and data capture
  always_comb begin
    sq1_d        = signalquality1;
    sq2_d        = signalquality2;
    sq3_d        = signalquality3;
    state_d      = state_q;
    target_d     = target_q;
    serving_d    = serving_q;
    prev_d       = prev_q;
    cand_d       = cand_q;
    ttt_cnt_d    = ttt_cnt_q;
    tout_cnt_d   = tout_cnt_q;
    ho_fail_d    = 1'b0;

    if (compare_enable && ((state_q == SERVING) || (state_q == HANDOVER))) begin
      final_data_d = DM_MD_data;
    end else begin
      final_data_d = final_data_q;
    end

    case (state_q)
      IDLE: begin
        if (best_sq_s >= SQ_MIN_V) begin
          target_d   = best_id_s;
          prev_d     = BS_NONE;
          tout_cnt_d = {TOUT_W{1'b0}};
          state_d    = HANDOVER;
        end else begin
          target_d   = BS_NONE;
        end
      end

      SERVING: begin
        // Losing the serving cell takes priority over any pending candidate
        if (serv_lost_s) begin
          target_d  = BS_NONE;
          serving_d = BS_NONE;
          ttt_cnt_d = {TTT_W{1'b0}};
          state_d   = IDLE;
        end else if (cand_ok_s) begin
          cand_d = best_id_s;
          if (TTT == 1) begin
            prev_d     = serving_q;
            target_d   = best_id_s;
            ttt_cnt_d  = {TTT_W{1'b0}};
            tout_cnt_d = {TOUT_W{1'b0}};
            state_d    = HANDOVER;
          end else begin
            ttt_cnt_d  = TTT_W'(1);
            state_d    = TRIGGER;
          end
        end else begin
          ttt_cnt_d = {TTT_W{1'b0}};
        end
      end

      TRIGGER: begin
        if (serv_lost_s) begin
          target_d  = BS_NONE;
          serving_d = BS_NONE;
          ttt_cnt_d = {TTT_W{1'b0}};
          state_d   = IDLE;
        end else if (!cand_ok_s || (best_id_s != cand_q)) begin
          ttt_cnt_d = {TTT_W{1'b0}};
          state_d   = SERVING;
        end else if (ttt_cnt_q == TTT_LAST) begin
          prev_d     = serving_q;
          target_d   = cand_q;
          ttt_cnt_d  = {TTT_W{1'b0}};
          tout_cnt_d = {TOUT_W{1'b0}};
          state_d    = HANDOVER;
        end else begin
          ttt_cnt_d  = ttt_cnt_q + TTT_W'(1);
        end
      end

      HANDOVER: begin
        // Acceptance on the final timeout cycle still counts as success
        if (compare_enable) begin
          serving_d  = target_q;
          tout_cnt_d = {TOUT_W{1'b0}};
          state_d    = SERVING;
        end else if (tout_cnt_q == TOUT_LAST) begin
          target_d   = prev_q;
          ho_fail_d  = 1'b1;
          tout_cnt_d = {TOUT_W{1'b0}};
          state_d    = (prev_q != BS_NONE) ? SERVING : IDLE;
        end else begin
          tout_cnt_d = tout_cnt_q + TOUT_W'(1);
        end
      end

      default: begin
        state_d    = IDLE;
        target_d   = BS_NONE;
        serving_d  = BS_NONE;
        prev_d     = BS_NONE;
        ttt_cnt_d  = {TTT_W{1'b0}};
        tout_cnt_d = {TOUT_W{1'b0}};
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sq1_q        <= {SQ_W{1'b0}};
      sq2_q        <= {SQ_W{1'b0}};
      sq3_q        <= {SQ_W{1'b0}};
      state_q      <= IDLE;
      target_q     <= BS_NONE;
      serving_q    <= BS_NONE;
      prev_q       <= BS_NONE;
      cand_q       <= BS_NONE;
      ttt_cnt_q    <= {TTT_W{1'b0}};
      tout_cnt_q   <= {TOUT_W{1'b0}};
      final_data_q <= {DATA_W{1'b0}};
      ho_fail_q    <= 1'b0;
    end else begin
      sq1_q        <= sq1_d;
      sq2_q        <= sq2_d;
      sq3_q        <= sq3_d;
      state_q      <= state_d;
      target_q     <= target_d;
      serving_q    <= serving_d;
      prev_q       <= prev_d;
      cand_q       <= cand_d;
      ttt_cnt_q    <= ttt_cnt_d;
      tout_cnt_q   <= tout_cnt_d;
      final_data_q <= final_data_d;
      ho_fail_q    <= ho_fail_d;
    end
  end

  assign MD_DM_sq1    = sq1_q;
  assign MD_DM_sq2    = sq2_q;
  assign MD_DM_sq3    = sq3_q;
  assign MD_DM_target = target_q;
  assign final_data   = final_data_q;
  assign ho_fail      = ho_fail_q;
  assign ho_busy      = state_busy(state_q);

endmodule

// File: tb/tb_md_handover_ctrl.sv
// Scoreboard bench for md_handover_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_md_handover_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sq1, sq2, sq3;
  logic       ce;
  logic [3:0] dmd;
  logic [7:0] o_sq1, o_sq2, o_sq3;
  logic [1:0] o_target;
  logic [3:0] o_fd;
  logic       o_busy, o_fail;

  localparam int F_TGT  = 0;
  localparam int F_BUSY = 1;
  localparam int F_FAIL = 2;
  localparam int F_FD   = 3;
  localparam int F_SQ1  = 4;
  localparam int F_SQ2  = 5;

  typedef struct {
    int    cyc;
    int    fld;
    int    val;
    string tag;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  md_handover_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .signalquality1 (sq1),
    .signalquality2 (sq2),
    .signalquality3 (sq3),
    .compare_enable (ce),
    .DM_MD_data     (dmd),
    .MD_DM_sq1      (o_sq1),
    .MD_DM_sq2      (o_sq2),
    .MD_DM_sq3      (o_sq3),
    .MD_DM_target   (o_target),
    .final_data     (o_fd),
    .ho_busy        (o_busy),
    .ho_fail        (o_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // expectation for the output as sampled k clock edges from now
  task automatic expect_at(input int k, input int f, input int v, input string t);
    exp_t e;
    e.cyc = cyc + k;
    e.fld = f;
    e.val = v;
    e.tag = t;
    sb.push_back(e);
  endtask

  function automatic int dut_fld(input int f);
    case (f)
      F_TGT:   return int'(o_target);
      F_BUSY:  return int'(o_busy);
      F_FAIL:  return int'(o_fail);
      F_FD:    return int'(o_fd);
      F_SQ1:   return int'(o_sq1);
      F_SQ2:   return int'(o_sq2);
      default: return -1;
    endcase
  endfunction

  function automatic logic fld_known(input int f);
    case (f)
      F_TGT:   return !$isunknown(o_target);
      F_BUSY:  return !$isunknown(o_busy);
      F_FAIL:  return !$isunknown(o_fail);
      F_FD:    return !$isunknown(o_fd);
      F_SQ1:   return !$isunknown(o_sq1);
      F_SQ2:   return !$isunknown(o_sq2);
      default: return 1'b0;
    endcase
  endfunction

  // monitor: compare every expectation stamped for this cycle
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        checks++;
        if (!fld_known(sb[i].fld) || dut_fld(sb[i].fld) != sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d got=%0d expected=%0d",
                   sb[i].tag, cyc, dut_fld(sb[i].fld), sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  initial begin
    reset = 1'b1;
    sq1 = 8'd0; sq2 = 8'd0; sq3 = 8'd0;
    ce = 1'b0; dmd = 4'd0;

    // reset state
    step(2);
    checks++;
    if (o_target !== 2'd0) begin
      errors++;
      $display("FAIL direct_rst_target got=%0d", o_target);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_busy got=%0d", o_busy);
    end
    checks++;
    if (o_fd !== 4'd0) begin
      errors++;
      $display("FAIL direct_rst_fd got=%0d", o_fd);
    end
    checks++;
    if (o_fail !== 1'b0) begin
      errors++;
      $display("FAIL direct_rst_fail got=%0d", o_fail);
    end
    expect_at(0, F_TGT,  0, "rst_target");
    expect_at(0, F_BUSY, 0, "rst_busy");
    expect_at(0, F_FAIL, 0, "rst_fail");
    expect_at(0, F_FD,   0, "rst_fd");
    expect_at(0, F_SQ1,  0, "rst_sq1");
    step(1);

    // attach to BS1 from IDLE, accept 3 cycles later
    reset = 1'b0;
    sq1 = 8'd50; sq2 = 8'd10; sq3 = 8'd10;
    expect_at(1, F_SQ1,  50, "t1_sq1_latency");
    expect_at(1, F_TGT,  0,  "t1_target_early");
    expect_at(2, F_TGT,  1,  "t1_target");
    expect_at(2, F_BUSY, 1,  "t1_busy_ho");
    step(3);
    ce = 1'b1; dmd = 4'h3;
    expect_at(1, F_FD,   3, "t1_fd");
    expect_at(1, F_BUSY, 0, "t1_serving");
    expect_at(1, F_TGT,  1, "t1_target_kept");
    expect_at(1, F_FAIL, 0, "t1_no_fail");
    step(1);
    ce = 1'b0;

    // candidate exactly HYST above serving: no handover
    sq1 = 8'd60; sq2 = 8'd68;
    expect_at(1,  F_SQ2,  68, "t2_sq2");
    expect_at(3,  F_TGT,  1,  "t2_eq_hyst_target");
    expect_at(3,  F_BUSY, 0,  "t2_eq_hyst_busy");
    expect_at(10, F_TGT,  1,  "t2_eq_hyst_target_late");
    expect_at(10, F_BUSY, 0,  "t2_eq_hyst_busy_late");
    step(10);

    // candidate held only 2 cycles: trigger aborted
    sq2 = 8'd80;
    expect_at(2, F_BUSY, 1, "t3_trigger");
    step(2);
    sq2 = 8'd50;
    expect_at(2, F_BUSY, 0, "t3_abort_busy");
    expect_at(2, F_TGT,  1, "t3_abort_target");
    expect_at(6, F_TGT,  1, "t3_target_late");
    expect_at(6, F_BUSY, 0, "t3_busy_late");
    step(6);

    // sq2=69 -> HO to BS2 after TTT, times out, retriggers, accepted on timeout cycle
    sq2 = 8'd69;
    expect_at(4,  F_TGT,  1,  "t2_ttt_not_yet");
    expect_at(5,  F_TGT,  2,  "t2_ttt_target");
    expect_at(5,  F_BUSY, 1,  "t2_ttt_busy");
    expect_at(20, F_TGT,  2,  "t4_before_tout");
    expect_at(20, F_FAIL, 0,  "t4_fail_early");
    expect_at(20, F_BUSY, 1,  "t4_busy_before");
    expect_at(21, F_TGT,  1,  "t4_revert_target");
    expect_at(21, F_FAIL, 1,  "t4_fail_pulse");
    expect_at(21, F_BUSY, 0,  "t4_back_serving");
    expect_at(22, F_FAIL, 0,  "t4_fail_one_cycle");
    expect_at(24, F_TGT,  1,  "t5_retrig_not_yet");
    expect_at(25, F_TGT,  2,  "t5_retrig_target");
    expect_at(40, F_TGT,  2,  "t5_tout_cycle_target");
    expect_at(40, F_BUSY, 1,  "t5_tout_cycle_busy");
    expect_at(41, F_FAIL, 0,  "t5_no_fail");
    expect_at(41, F_TGT,  2,  "t5_target_bs2");
    expect_at(41, F_BUSY, 0,  "t5_serving");
    expect_at(41, F_FD,   7,  "t5_fd_7");
    expect_at(42, F_FD,   10, "t5_fd_a");
    step(2);
    ce = 1'b1; dmd = 4'hE;
    expect_at(1, F_FD, 3, "trig_ce_ignored");
    step(1);
    ce = 1'b0;
    step(37);
    ce = 1'b1; dmd = 4'h7;
    step(1);
    dmd = 4'hA;
    step(1);
    ce = 1'b0;

    // serving BS2 lost while BS1 is a candidate: loss wins, then re-attach to BS1
    sq2 = 8'd20;
    expect_at(2, F_TGT,  0, "t6_loss_target");
    expect_at(2, F_BUSY, 0, "t6_loss_idle");
    expect_at(3, F_TGT,  1, "t6_reattach");
    expect_at(3, F_BUSY, 1, "t6_reattach_busy");
    step(5);

    // asynchronous reset in HANDOVER
    reset = 1'b1;
    expect_at(0, F_TGT,  0, "t6_arst_target");
    expect_at(0, F_BUSY, 0, "t6_arst_busy");
    expect_at(0, F_FD,   0, "t6_arst_fd");
    expect_at(0, F_SQ1,  0, "t6_arst_sq1");
    expect_at(0, F_FAIL, 0, "t6_arst_fail");
    step(2);
    checks++;
    if (o_target !== 2'd0) begin
      errors++;
      $display("FAIL direct_arst_target got=%0d", o_target);
    end
    checks++;
    if (o_sq1 !== 8'd0) begin
      errors++;
      $display("FAIL direct_arst_sq1 got=%0d", o_sq1);
    end
    reset = 1'b0;

    // attach from IDLE then time out: prev is none, back to IDLE
    expect_at(1,  F_TGT,  0, "idle_tgt_early");
    expect_at(2,  F_TGT,  1, "idle_attach");
    expect_at(2,  F_BUSY, 1, "idle_attach_busy");
    expect_at(17, F_TGT,  1, "idle_before_tout");
    expect_at(18, F_TGT,  0, "idle_tout_target");
    expect_at(18, F_FAIL, 1, "idle_tout_fail");
    expect_at(18, F_BUSY, 0, "idle_tout_idle");
    expect_at(19, F_FAIL, 0, "idle_fail_one_cycle");
    expect_at(19, F_TGT,  1, "idle_reattach");
    step(18);
    ce = 1'b1; dmd = 4'h5;
    expect_at(1, F_FD, 0, "idle_ce_ignored");
    step(1);
    ce = 1'b0;
    step(3);

    foreach (sb[i]) begin
      checks++;
      errors++;
      $display("FAIL %s never sampled (stamp=%0d now=%0d)", sb[i].tag, sb[i].cyc, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
